// File: rtl/seq_detect_prog.sv
// Programmable SEQ_LEN-word sequence detector with gap tolerance, overlap/non-overlap modes
// and a saturating match counter. Optional per-bit compare masks under SEQ_DETECT_MASK_EN.
module seq_detect_prog #(
  parameter int DATA_W = 8,
  parameter int SEQ_LEN = 4,
  parameter int CNT_W = 16,
  parameter logic [DATA_W*SEQ_LEN-1:0] RST_PATTERN = 32'hABCDEF24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            data,
  input  logic                         overlap_en,
  input  logic                         cfg_we,
  input  logic [$clog2(SEQ_LEN)-1:0]   cfg_idx,
  input  logic [DATA_W-1:0]            cfg_word,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [DATA_W-1:0]            cfg_mask,
`endif
  input  logic                         cnt_clr,
  output logic                         flag,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [$clog2(SEQ_LEN+1)-1:0] fill
);

  localparam int FILL_W = $clog2(SEQ_LEN+1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN-1);

  logic [DATA_W-1:0] pattern [SEQ_LEN];
  // hist[0] is the oldest word, hist[SEQ_LEN-2] the newest
  logic [DATA_W-1:0] hist [SEQ_LEN-1];
`ifdef SEQ_DETECT_MASK_EN
  logic [DATA_W-1:0] mask [SEQ_LEN];
`endif

  logic               accept;
  logic               hit;
  logic [SEQ_LEN-1:0] word_ok;
  logic               idx_ok;

  assign accept = in_valid && !cfg_we;
  assign idx_ok = 32'(cfg_idx) < SEQ_LEN;

  always_comb begin
    word_ok = '0;
    for (int i = 0; i < SEQ_LEN-1; i++) begin
`ifdef SEQ_DETECT_MASK_EN
      word_ok[i] = ((hist[i] ^ pattern[i]) & ~mask[i]) == '0;
`else
      word_ok[i] = hist[i] == pattern[i];
`endif
    end
`ifdef SEQ_DETECT_MASK_EN
    word_ok[SEQ_LEN-1] = ((data ^ pattern[SEQ_LEN-1]) & ~mask[SEQ_LEN-1]) == '0;
`else
    word_ok[SEQ_LEN-1] = data == pattern[SEQ_LEN-1];
`endif
    hit = accept && (fill == FILL_FULL) && (&word_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SEQ_LEN; i++) begin
        pattern[i] <= RST_PATTERN[(SEQ_LEN-1-i)*DATA_W +: DATA_W];
`ifdef SEQ_DETECT_MASK_EN
        mask[i] <= '0;
`endif
      end
      for (int i = 0; i < SEQ_LEN-1; i++) hist[i] <= '0;
      fill      <= '0;
      flag      <= 1'b0;
      match_cnt <= '0;
    end else begin
      flag <= hit;

      if (cfg_we) begin
        if (idx_ok) begin
          pattern[cfg_idx] <= cfg_word;
`ifdef SEQ_DETECT_MASK_EN
          mask[cfg_idx] <= cfg_mask;
`endif
        end
        for (int i = 0; i < SEQ_LEN-1; i++) hist[i] <= '0;
        fill <= '0;
      end else if (in_valid) begin
        if (hit && !overlap_en) begin
          for (int i = 0; i < SEQ_LEN-1; i++) hist[i] <= '0;
          fill <= '0;
        end else begin
          for (int i = 0; i < SEQ_LEN-2; i++) hist[i] <= hist[i+1];
          hist[SEQ_LEN-2] <= data;
          if (fill != FILL_FULL) fill <= fill + 1'b1;
        end
      end

      // a clear coinciding with a match leaves exactly that one match counted
      if (cnt_clr)
        match_cnt <= hit ? CNT_W'(1) : '0;
      else if (hit && (match_cnt != {CNT_W{1'b1}}))
        match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed plan steps plus randomized traffic
// compared against a queue-based window model. Build with SEQ_DETECT_MASK_EN to cover masks.
module tb_seq_detect_prog;

  localparam int DW = 8;
  localparam int SL = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] data;
  logic          overlap_en;
  logic          cfg_we;
  logic [1:0]    cfg_idx;
  logic [DW-1:0] cfg_word;
  logic [DW-1:0] cfg_mask;
  logic          cnt_clr;
  logic          flag;
  logic [CW-1:0] match_cnt;
  logic [2:0]    fill;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [DW-1:0] mpat  [SL];
  logic [DW-1:0] mmask [SL];
  logic [DW-1:0] win [$];
  int            mcnt;
  logic          exp_flag;

  always #5 clk = ~clk;

  seq_detect_prog #(.DATA_W(DW), .SEQ_LEN(SL), .CNT_W(CW), .RST_PATTERN(32'hABCDEF24)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .data(data),
    .overlap_en(overlap_en),
    .cfg_we(cfg_we),
    .cfg_idx(cfg_idx),
    .cfg_word(cfg_word),
`ifdef SEQ_DETECT_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .cnt_clr(cnt_clr),
    .flag(flag),
    .match_cnt(match_cnt),
    .fill(fill)
  );

  function automatic bit same(logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] m);
    return ((a ^ b) & ~m) == '0;
  endfunction

  task automatic model_reset();
    mpat[0] = 8'hAB; mpat[1] = 8'hCD; mpat[2] = 8'hEF; mpat[3] = 8'h24;
    for (int i = 0; i < SL; i++) mmask[i] = '0;
    win.delete();
    mcnt = 0;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // one clock: drive inputs, advance model, then compare registered outputs after the edge
  task automatic step(input logic r, input logic v, input logic [DW-1:0] d, input logic ov,
                      input logic we, input logic [1:0] idx, input logic [DW-1:0] w,
                      input logic [DW-1:0] m, input logic clr, input string tag);
    bit match;
    rst = r; in_valid = v; data = d; overlap_en = ov;
    cfg_we = we; cfg_idx = idx; cfg_word = w; cfg_mask = m; cnt_clr = clr;

    match = 1'b0;
    if (!r && v && !we && win.size() >= SL-1) begin
      match = 1'b1;
      for (int k = 0; k < SL-1; k++)
        if (!same(win[win.size()-(SL-1)+k], mpat[k], mmask[k])) match = 1'b0;
      if (!same(d, mpat[SL-1], mmask[SL-1])) match = 1'b0;
    end

    if (r) begin
      model_reset();
    end else begin
      if (we) begin
        mpat[idx] = w;
`ifdef SEQ_DETECT_MASK_EN
        mmask[idx] = m;
`endif
        win.delete();
      end else if (v) begin
        if (match && !ov) win.delete();
        else begin
          win.push_back(d);
          if (win.size() > SL-1) void'(win.pop_front());
        end
      end
      if (clr) mcnt = match ? 1 : 0;
      else if (match && mcnt < (1 << CW) - 1) mcnt++;
    end
    exp_flag = match;

    @(posedge clk);
    #1;
    check({tag, ".flag"}, int'(flag), int'(exp_flag));
    check({tag, ".cnt"}, int'(match_cnt), mcnt);
    check({tag, ".fill"}, int'(fill), win.size());
  endtask

  task automatic word(input logic [DW-1:0] d, input logic ov, input string tag);
    step(1'b0, 1'b1, d, ov, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, tag);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, "reset");
  endtask

  task automatic prog(input logic [1:0] idx, input logic [DW-1:0] w, input logic [DW-1:0] m);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, idx, w, m, 1'b0, "prog");
  endtask

  initial begin
    logic [DW-1:0] d, w, m;
    logic r, v, ov, we, clr;
    logic [1:0] idx;

    model_reset();
    rst = 1'b1; in_valid = 1'b0; data = '0; overlap_en = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_word = '0; cfg_mask = '0; cnt_clr = 1'b0;

    // 1: reset pattern detected once
    do_reset();
    check("rst.flag_const", int'(flag), 0);
    word(8'hAB, 1'b1, "t1"); word(8'hCD, 1'b1, "t1"); word(8'hEF, 1'b1, "t1");
    word(8'h24, 1'b1, "t1");
    check("t1.flag_const", int'(flag), 1);
    check("t1.cnt_const", int'(match_cnt), 1);
    idle("t1.after");

    // 2: gaps keep a partial sequence; a foreign word breaks it
    do_reset();
    word(8'hAB, 1'b1, "t2a"); idle("t2a"); idle("t2a"); idle("t2a");
    word(8'hCD, 1'b1, "t2a"); idle("t2a"); word(8'hEF, 1'b1, "t2a"); word(8'h24, 1'b1, "t2a");
    word(8'hAB, 1'b1, "t2b"); word(8'hCD, 1'b1, "t2b"); word(8'h00, 1'b1, "t2b");
    word(8'hEF, 1'b1, "t2b"); word(8'h24, 1'b1, "t2b");
    check("t2.cnt_const", int'(match_cnt), 1);

    // 3: repeated-word pattern, overlapping then non-overlapping
    do_reset();
    for (int i = 0; i < SL; i++) prog(2'(i), 8'h11, 8'h00);
    check("t3.fill_after_prog", int'(fill), 0);
    for (int i = 0; i < 6; i++) word(8'h11, 1'b1, "t3ov");
    check("t3.ov_cnt_const", int'(match_cnt), 3);
    do_reset();
    for (int i = 0; i < SL; i++) prog(2'(i), 8'h11, 8'h00);
    for (int i = 0; i < 6; i++) word(8'h11, 1'b0, "t3nov");
    check("t3.nov_cnt_const", int'(match_cnt), 1);

    // 4: reset mid-sequence; cfg_we drops a same-cycle word
    do_reset();
    word(8'hAB, 1'b1, "t4"); word(8'hCD, 1'b1, "t4"); word(8'hEF, 1'b1, "t4");
    do_reset();
    check("t4.fill_rst", int'(fill), 0);
    word(8'h24, 1'b1, "t4");
    check("t4.fill_one", int'(fill), 1);
    word(8'hAB, 1'b1, "t4"); word(8'hCD, 1'b1, "t4");
    step(1'b0, 1'b1, 8'hEF, 1'b1, 1'b1, 2'd3, 8'h24, 8'h00, 1'b0, "t4.drop");
    check("t4.fill_drop", int'(fill), 0);

    // 5: counter saturation and clear-with-match
    do_reset();
    for (int i = 0; i < SL; i++) prog(2'(i), 8'h11, 8'h00);
    for (int i = 0; i < SL-1; i++) word(8'h11, 1'b1, "t5.prime");
    for (int i = 0; i < 5; i++) word(8'h11, 1'b1, "t5.sat");
    check("t5.sat_const", int'(match_cnt), 3);
    step(1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, "t5.clr");
    check("t5.clr_const", int'(match_cnt), 1);
    step(1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, "t5.clr_idle");

    // 6: masked compare on word 2
    do_reset();
    prog(2'd2, 8'hEF, 8'h0F);
    word(8'hAB, 1'b1, "t6"); word(8'hCD, 1'b1, "t6"); word(8'hE3, 1'b1, "t6");
    word(8'h24, 1'b1, "t6");
`ifdef SEQ_DETECT_MASK_EN
    check("t6.flag_const", int'(flag), 1);
`else
    check("t6.flag_const", int'(flag), 0);
`endif

    // randomized traffic against the window model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      r   = ($urandom_range(0, 149) == 0);
      we  = ($urandom_range(0, 11) == 0);
      v   = ($urandom_range(0, 3) != 0);
      ov  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 29) == 0);
      idx = 2'($urandom_range(0, SL-1));
      w   = ($urandom_range(0, 1) != 0) ? 8'h5A : 8'hC3;
      m   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      case ($urandom_range(0, 3))
        0, 1:    d = mpat[$urandom_range(0, SL-1)];
        2:       d = ($urandom_range(0, 1) != 0) ? 8'h5A : 8'hC3;
        default: d = 8'($urandom);
      endcase
      step(r, v, d, ov, we, idx, w, m, clr, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
